// File: rtl/dec_hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// dec_hazard_scoreboard_pkg
// Shared definitions for the DEC-stage RAW hazard scoreboard:
//   - stage indices of the tracked pipeline slots (EXE, MEM, WB)
//   - forward-select encodings used when DEC_HAZARD_FORWARDING_EN is defined
//   - the scoreboard entry record {valid, dst, is_load}
//   - small helpers shared by the top level
// No ports (package).
// -----------------------------------------------------------------------------
package dec_hazard_scoreboard_pkg;

  // Scoreboard slot positions; slot 0 mirrors DEC/EXE, the last one MEM/WB.
  localparam int unsigned STG_EXE = 32'd0;
  localparam int unsigned STG_MEM = 32'd1;
  localparam int unsigned STG_WB  = 32'd2;

  // Destination field width inside an entry. Register indices narrower than
  // this are zero-extended, so one struct serves any REG_INDEX_BIT_WIDTH up
  // to this size.
  localparam int unsigned SB_DST_W = 32'd8;

  // Operand source selection for the EXE operand muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // One in-flight register write.
  typedef struct packed {
    logic                valid;
    logic [SB_DST_W-1:0] dst;
    logic                is_load;
  } sb_entry_t;

  // True when a used source operand reads the register this entry will write.
  function automatic logic src_hit(input sb_entry_t      e,
                                   input logic [SB_DST_W-1:0] src,
                                   input logic           used);
    return e.valid && used && (e.dst == src);
  endfunction

  // Map a scoreboard slot to the bypass path that carries its result.
  function automatic fwd_sel_e stage_to_fwd(input int unsigned stg);
    fwd_sel_e sel;
    case (stg)
      STG_EXE: sel = FWD_EXE;
      STG_MEM: sel = FWD_MEM;
      STG_WB:  sel = FWD_WB;
      default: sel = FWD_RF;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dec_hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// dec_hazard_scoreboard_if
// Bundles the DEC-side instruction description and the hazard controls
// returned to the front end.
//   master : decode/control side - drives dec_* and exe_flush, reads results
//   slave  : the scoreboard      - reads dec_* and exe_flush, drives results
// Signals:
//   dec_valid, dec_src1(_used), dec_src2(_used), dec_wrt_en, dec_dst,
//   dec_is_load, exe_flush                       (master -> slave)
//   stall, bubble, inflight_valid[PIPE_DEPTH], stall_count[CNT_WIDTH],
//   fwd_sel1/fwd_sel2 (only with DEC_HAZARD_FORWARDING_EN) (slave -> master)
// Optional feature macro: DEC_HAZARD_FORWARDING_EN
// -----------------------------------------------------------------------------
interface dec_hazard_scoreboard_if #(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 32'd4,
  parameter int unsigned PIPE_DEPTH          = 32'd3,
  parameter int unsigned CNT_WIDTH           = 32'd32
);

  logic                           dec_valid;
  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1;
  logic                           dec_src1_used;
  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2;
  logic                           dec_src2_used;
  logic                           dec_wrt_en;
  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dst;
  logic                           dec_is_load;
  logic                           exe_flush;

  logic                           stall;
  logic                           bubble;
  logic [PIPE_DEPTH-1:0]          inflight_valid;
  logic [CNT_WIDTH-1:0]           stall_count;

`ifdef DEC_HAZARD_FORWARDING_EN
  logic [1:0]                     fwd_sel1;
  logic [1:0]                     fwd_sel2;

  modport master (
    output dec_valid, dec_src1, dec_src1_used, dec_src2, dec_src2_used,
           dec_wrt_en, dec_dst, dec_is_load, exe_flush,
    input  stall, bubble, inflight_valid, stall_count, fwd_sel1, fwd_sel2
  );

  modport slave (
    input  dec_valid, dec_src1, dec_src1_used, dec_src2, dec_src2_used,
           dec_wrt_en, dec_dst, dec_is_load, exe_flush,
    output stall, bubble, inflight_valid, stall_count, fwd_sel1, fwd_sel2
  );
`else
  modport master (
    output dec_valid, dec_src1, dec_src1_used, dec_src2, dec_src2_used,
           dec_wrt_en, dec_dst, dec_is_load, exe_flush,
    input  stall, bubble, inflight_valid, stall_count
  );

  modport slave (
    input  dec_valid, dec_src1, dec_src1_used, dec_src2, dec_src2_used,
           dec_wrt_en, dec_dst, dec_is_load, exe_flush,
    output stall, bubble, inflight_valid, stall_count
  );
`endif

endinterface

// File: rtl/dec_hazard_scoreboard_sb_entry_reg.sv
// -----------------------------------------------------------------------------
// dec_hazard_scoreboard_sb_entry_reg
// One scoreboard slot: a resettable, enabled register holding a sb_entry_t.
// Ports:
//   clk_i    clock, rising edge
//   reset_i  asynchronous active-low reset (clears the slot)
//   en_i     load enable
//   d_i      next entry value
//   q_o      current entry value
// -----------------------------------------------------------------------------
module dec_hazard_scoreboard_sb_entry_reg
  import dec_hazard_scoreboard_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      en_i,
  input  sb_entry_t d_i,
  output sb_entry_t q_o
);

  sb_entry_t entry_q;

  // Slot storage: cleared by reset, loaded when enabled.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      entry_q <= '0;
    end else if (en_i) begin
      entry_q <= d_i;
    end else begin
      entry_q <= entry_q;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/dec_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// dec_hazard_scoreboard
// Tracks register writes in flight in EXE, MEM and WB and resolves RAW
// hazards for the instruction in DEC. The scoreboard shifts every cycle in
// lock-step with DEC/EXE -> EXE/MEM -> MEM/WB; a stalled or killed DEC slot
// shifts in an empty entry, so a stall always drains on its own.
// Ports:
//   clk_i    clock, rising edge
//   reset_i  asynchronous active-low reset
//   bus      dec_hazard_scoreboard_if.slave
//            in : dec_valid, dec_src1/_used, dec_src2/_used, dec_wrt_en,
//                 dec_dst, dec_is_load, exe_flush
//            out: stall (hold PC and FET/DEC), bubble (zero write enables into
//                 DEC/EXE), inflight_valid, stall_count (saturating),
//                 fwd_sel1/fwd_sel2 (forwarding build only)
// Optional feature macro: DEC_HAZARD_FORWARDING_EN
//   defined  : stall only on load-use against EXE, and report per-source
//              bypass selects for the youngest matching stage
//   undefined: stall on any match in EXE/MEM/WB (register file does not
//              bypass same-cycle writes, so WB still counts)
// stall/bubble/fwd_sel are combinational from scoreboard state and DEC
// inputs (zero-cycle latency); stall_count is registered.
// -----------------------------------------------------------------------------
module dec_hazard_scoreboard
  import dec_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 32'd4,
  parameter int unsigned PIPE_DEPTH          = 32'd3,
  parameter int unsigned CNT_WIDTH           = 32'd32
) (
  input logic                   clk_i,
  input logic                   reset_i,
  dec_hazard_scoreboard_if.slave bus
);

  sb_entry_t             entry_q [PIPE_DEPTH];
  sb_entry_t             entry_d [PIPE_DEPTH];

  logic [SB_DST_W-1:0]   src1_s;
  logic [SB_DST_W-1:0]   src2_s;
  logic [PIPE_DEPTH-1:0] match1_s;
  logic [PIPE_DEPTH-1:0] match2_s;
  logic                  hazard_s;
  logic                  stall_s;
  logic                  bubble_s;
  logic                  issue_s;
  logic [PIPE_DEPTH-1:0] inflight_s;

  logic [CNT_WIDTH-1:0]  stall_count_q;
  logic [CNT_WIDTH-1:0]  stall_count_d;

`ifdef DEC_HAZARD_FORWARDING_EN
  fwd_sel_e              fwd1_s;
  fwd_sel_e              fwd2_s;
`endif

  // Per-slot source matches and the hazard decision.
  always_comb begin
    src1_s   = SB_DST_W'(bus.dec_src1);
    src2_s   = SB_DST_W'(bus.dec_src2);
    match1_s = '0;
    match2_s = '0;
    for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
      match1_s[i] = src_hit(entry_q[i], src1_s, bus.dec_src1_used);
      match2_s[i] = src_hit(entry_q[i], src2_s, bus.dec_src2_used);
    end
`ifdef DEC_HAZARD_FORWARDING_EN
    // Slot 0 is the youngest; a load there has no data until MEM, so only
    // that case must wait. Everything else is covered by a bypass path.
    hazard_s = (match1_s[0] || match2_s[0]) && entry_q[0].is_load;
`else
    hazard_s = |(match1_s | match2_s);
`endif
  end

`ifdef DEC_HAZARD_FORWARDING_EN
  // Bypass select per source; walking oldest to youngest lets the youngest
  // (most recent) producer win.
  always_comb begin
    fwd1_s = FWD_RF;
    fwd2_s = FWD_RF;
    for (int i = int'(PIPE_DEPTH) - 1; i >= 0; i--) begin
      if (match1_s[i]) begin
        fwd1_s = stage_to_fwd(unsigned'(i));
      end else begin
        fwd1_s = fwd1_s;
      end
      if (match2_s[i]) begin
        fwd2_s = stage_to_fwd(unsigned'(i));
      end else begin
        fwd2_s = fwd2_s;
      end
    end
  end
`endif

  // Front-end controls; reset_i gates them so an asserted reset drops the
  // stall at once and forces a bubble regardless of dec_valid.
  always_comb begin
    stall_s  = reset_i && bus.dec_valid && !bus.exe_flush && hazard_s;
    bubble_s = !reset_i || !bus.dec_valid || bus.exe_flush || stall_s;
    issue_s  = reset_i && bus.dec_valid && !stall_s && !bus.exe_flush;
  end

  // Next scoreboard contents: the issuing instruction enters slot 0, every
  // other slot takes its younger neighbour, the last slot retires.
  always_comb begin
    for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
      entry_d[i] = '0;
    end
    if (issue_s) begin
      entry_d[0].valid   = bus.dec_wrt_en;
      entry_d[0].dst     = SB_DST_W'(bus.dec_dst);
      entry_d[0].is_load = bus.dec_is_load;
    end else begin
      entry_d[0] = '0;
    end
    for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
      entry_d[i] = entry_q[i-1];
    end
  end

  for (genvar g = 0; g < int'(PIPE_DEPTH); g++) begin : g_entry
    dec_hazard_scoreboard_sb_entry_reg u_sb_entry_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (1'b1),
      .d_i     (entry_d[g]),
      .q_o     (entry_q[g])
    );
  end

  // Visibility of occupied slots.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
      inflight_s[i] = entry_q[i].valid;
    end
  end

  // Stall counter next value: count stalled cycles, stick at all-ones.
  always_comb begin
    if (stall_s && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall          = stall_s;
  assign bus.bubble         = bubble_s;
  assign bus.inflight_valid = inflight_s;
  assign bus.stall_count    = stall_count_q;
`ifdef DEC_HAZARD_FORWARDING_EN
  assign bus.fwd_sel1       = fwd1_s;
  assign bus.fwd_sel2       = fwd2_s;
`endif

endmodule

// File: tb/tb_dec_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_dec_hazard_scoreboard
// Directed bench for dec_hazard_scoreboard. A history list of issued
// instructions (youngest first) predicts the outputs every cycle; a few
// hand-computed literals pin the expected behaviour. Built with
// CNT_WIDTH = 4 so counter saturation is reachable.
// Works with and without DEC_HAZARD_FORWARDING_EN.
// -----------------------------------------------------------------------------
module tb_dec_hazard_scoreboard;

  localparam int RW    = 4;
  localparam int DEPTH = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk;
  logic reset_i;

  dec_hazard_scoreboard_if #(
    .REG_INDEX_BIT_WIDTH (RW),
    .PIPE_DEPTH          (DEPTH),
    .CNT_WIDTH           (CW)
  ) bus ();

  dec_hazard_scoreboard #(
    .REG_INDEX_BIT_WIDTH (RW),
    .PIPE_DEPTH          (DEPTH),
    .CNT_WIDTH           (CW)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Issued-instruction history: index 0 = in EXE, 1 = MEM, 2 = WB.
  typedef struct { bit v; int dst; bit ld; } rec_t;
  rec_t hist[$];
  int   m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    rec_t e;
    e.v = 1'b0; e.dst = 0; e.ld = 1'b0;
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back(e);
    m_cnt = 0;
  endfunction

  // Does the DEC instruction read what history slot a writes?
  function automatic bit reads(input int a);
    return hist[a].v &&
           ((bus.dec_src1_used && int'(bus.dec_src1) == hist[a].dst) ||
            (bus.dec_src2_used && int'(bus.dec_src2) == hist[a].dst));
  endfunction

  function automatic bit m_stall();
    bit haz;
    haz = 1'b0;
`ifdef DEC_HAZARD_FORWARDING_EN
    haz = reads(0) && hist[0].ld;
`else
    for (int a = 0; a < DEPTH; a++) if (reads(a)) haz = 1'b1;
`endif
    return reset_i && bus.dec_valid && !bus.exe_flush && haz;
  endfunction

`ifdef DEC_HAZARD_FORWARDING_EN
  // Bypass code = 1 + age of the most recent writer of src, 0 if none.
  function automatic int m_fwd(input int src, input bit used);
    for (int a = 0; a < DEPTH; a++)
      if (used && hist[a].v && hist[a].dst == src) return a + 1;
    return 0;
  endfunction
`endif

  task automatic compare_all();
    bit st;
    logic [31:0] inf;
    if (!reset_i) model_clear();
    st  = m_stall();
    inf = '0;
    for (int a = 0; a < DEPTH; a++) inf[a] = hist[a].v;
    check("stall",    32'(bus.stall), 32'(st));
    check("bubble",   32'(bus.bubble), 32'(!reset_i || !bus.dec_valid || bus.exe_flush || st));
    check("inflight", 32'(bus.inflight_valid), inf);
    check("count",    32'(bus.stall_count), 32'(m_cnt));
`ifdef DEC_HAZARD_FORWARDING_EN
    check("fwd1", 32'(bus.fwd_sel1), 32'(m_fwd(int'(bus.dec_src1), bus.dec_src1_used)));
    check("fwd2", 32'(bus.fwd_sel2), 32'(m_fwd(int'(bus.dec_src2), bus.dec_src2_used)));
`endif
  endtask

  function automatic void model_step();
    bit   st;
    rec_t e;
    if (!reset_i) begin
      model_clear();
    end else begin
      st   = m_stall();
      e.v  = 1'b0; e.dst = 0; e.ld = 1'b0;
      if (bus.dec_valid && !st && !bus.exe_flush) begin
        e.v = bus.dec_wrt_en; e.dst = int'(bus.dec_dst); e.ld = bus.dec_is_load;
      end
      hist.push_front(e);
      void'(hist.pop_back());
      if (st && m_cnt < CMAX) m_cnt++;
    end
  endfunction

  // Inputs change just after the falling edge; compare before the rising edge.
  task automatic cycle();
    #2;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_dec(input bit v, input int s1, input bit s1u, input int s2, input bit s2u,
                         input bit wen, input int dst, input bit ld, input bit fl);
    bus.dec_valid     = v;
    bus.dec_src1      = RW'(s1);
    bus.dec_src1_used = s1u;
    bus.dec_src2      = RW'(s2);
    bus.dec_src2_used = s2u;
    bus.dec_wrt_en    = wen;
    bus.dec_dst       = RW'(dst);
    bus.dec_is_load   = ld;
    bus.exe_flush     = fl;
  endtask

  task automatic idle(input int n);
    set_dec(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Hold the current DEC instruction until it issues; returns stall cycles.
  task automatic hold_until_issue(output int n);
    bit seen;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      seen = bus.stall;
      if (seen) n++;
      cycle();
      if (!seen) break;
    end
  endtask

  int n_st;

  initial begin
    reset_i = 1'b0;
    model_clear();
    // Reset with a valid DEC instruction present.
    set_dec(1'b1, 3, 1'b1, 4, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("rst_stall",    32'(bus.stall), 32'd0);
    check("rst_bubble",   32'(bus.bubble), 32'd1);
    check("rst_inflight", 32'(bus.inflight_valid), 32'd0);
    check("rst_count",    32'(bus.stall_count), 32'd0);
    cycle();
    cycle();
    reset_i = 1'b1;
    idle(1);

    // ADD r3 <- r1,r2 ; SUB r6 <- r3
    set_dec(1'b1, 1, 1'b1, 2, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    cycle();
    set_dec(1'b1, 3, 1'b1, 0, 1'b0, 1'b1, 6, 1'b0, 1'b0);
    hold_until_issue(n_st);
    #1;
`ifdef DEC_HAZARD_FORWARDING_EN
    check("raw_stall_cycles", 32'(n_st), 32'd0);
    check("raw_count",        32'(bus.stall_count), 32'd0);
`else
    check("raw_stall_cycles", 32'(n_st), 32'd3);
    check("raw_count",        32'(bus.stall_count), 32'd3);
`endif
    idle(3);

    // Store (no register write) naming r5, then a reader of r5.
    set_dec(1'b1, 1, 1'b1, 5, 1'b1, 1'b0, 5, 1'b0, 1'b0);
    cycle();
    set_dec(1'b1, 5, 1'b1, 5, 1'b1, 1'b1, 8, 1'b0, 1'b0);
    #1;
    check("store_stall",    32'(bus.stall), 32'd0);
    check("store_inflight", 32'(bus.inflight_valid), 32'd0);
    cycle();
    idle(3);

    // ADD r7, then dependent SUB while EXE resolves a taken branch.
    set_dec(1'b1, 1, 1'b1, 2, 1'b1, 1'b1, 7, 1'b0, 1'b0);
    cycle();
    set_dec(1'b1, 7, 1'b1, 0, 1'b0, 1'b1, 9, 1'b0, 1'b1);
    #1;
    check("flush_stall",  32'(bus.stall), 32'd0);
    check("flush_bubble", 32'(bus.bubble), 32'd1);
    cycle();
    idle(0);
    #1;
    check("flush_inflight", 32'(bus.inflight_valid), 32'b010);
    cycle();
    idle(3);

`ifdef DEC_HAZARD_FORWARDING_EN
    // LW r2 ; ADD r10 <- r2,r2 : one load-use stall, then bypass from MEM.
    set_dec(1'b1, 1, 1'b1, 0, 1'b0, 1'b1, 2, 1'b1, 1'b0);
    cycle();
    set_dec(1'b1, 2, 1'b1, 2, 1'b1, 1'b1, 10, 1'b0, 1'b0);
    #1;
    check("lu_stall_1", 32'(bus.stall), 32'd1);
    cycle();
    #1;
    check("lu_stall_2", 32'(bus.stall), 32'd0);
    check("lu_fwd1",    32'(bus.fwd_sel1), 32'd2);
    check("lu_fwd2",    32'(bus.fwd_sel2), 32'd2);
    cycle();
    // ALU r4 ; use r4 : bypass from EXE, no stall.
    set_dec(1'b1, 1, 1'b1, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    cycle();
    set_dec(1'b1, 4, 1'b1, 0, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    #1;
    check("alu_stall", 32'(bus.stall), 32'd0);
    check("alu_fwd1",  32'(bus.fwd_sel1), 32'd1);
    cycle();
    idle(3);
`endif

    // Repeated load-use pairs drive the 4-bit counter past all-ones.
    for (int r = 0; r < 16; r++) begin
      set_dec(1'b1, 1, 1'b1, 0, 1'b0, 1'b1, 3, 1'b1, 1'b0);
      cycle();
      set_dec(1'b1, 3, 1'b1, 3, 1'b1, 1'b1, 12, 1'b0, 1'b0);
      hold_until_issue(n_st);
    end
    #1;
    check("sat_count", 32'(bus.stall_count), 32'd15);
    idle(3);

    // Reset asserted in the middle of a stall.
    set_dec(1'b1, 1, 1'b1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0);
    cycle();
    set_dec(1'b1, 3, 1'b1, 0, 1'b0, 1'b1, 6, 1'b0, 1'b0);
    #1;
    check("mid_stall_before", 32'(bus.stall), 32'd1);
    reset_i = 1'b0;
    #1;
    check("mid_stall_after",  32'(bus.stall), 32'd0);
    check("mid_bubble_after", 32'(bus.bubble), 32'd1);
    check("mid_count_after",  32'(bus.stall_count), 32'd0);
    cycle();
    reset_i = 1'b1;
    idle(1);
    #1;
    check("post_rst_inflight", 32'(bus.inflight_valid), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
